aes_out_sig: RTL and testbench



---
 rtl/aes_out_sig.sv | 134 +++++++++++++
 tb/tb_aes_out_sig.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_out_sig.sv
// rtl/aes_out_sig.sv - aes_128 output tracker: latency valid pipe, 128-bit MISR signature, test counter
// Optional golden-signature compare is built when AES_SIG_GOLDEN_EN is defined.
module aes_out_sig #(
    parameter int DATA_W  = 128,
    parameter int LATENCY = 21,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_tests,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_data,
`ifdef AES_SIG_GOLDEN_EN
    input  logic [DATA_W-1:0] i_golden_sig,
    output logic              o_pass,
`endif
    output logic [DATA_W-1:0] o_sig,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Taps are maximal only for DATA_W=128; other widths wrap them modulo DATA_W.
    localparam int TAP0 = 127 % DATA_W;
    localparam int TAP1 = 125 % DATA_W;
    localparam int TAP2 = 100 % DATA_W;
    localparam int TAP3 = 98 % DATA_W;

    state_t             state, state_n;
    logic [LATENCY-1:0] pipe, pipe_n, pipe_shift;
    logic [CNT_W-1:0]   issued, issued_n;
    logic [CNT_W-1:0]   num, num_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DATA_W-1:0]  sig, sig_n, misr_next;
    logic               push, tail, fb;

    assign push = (state == ST_RUN) && !i_start && i_in_valid && (issued < num);
    assign tail = pipe[LATENCY-1];
    assign fb   = sig[TAP0] ^ sig[TAP1] ^ sig[TAP2] ^ sig[TAP3];
    assign misr_next = {sig[DATA_W-2:0], fb} ^ i_data;

    generate
        if (LATENCY == 1) begin : g_pipe_single
            assign pipe_shift = push;
        end else begin : g_pipe_multi
            assign pipe_shift = {pipe[LATENCY-2:0], push};
        end
    endgenerate

`ifdef AES_SIG_GOLDEN_EN
    logic pass, pass_n;
`endif

    always_comb begin
        state_n  = state;
        pipe_n   = pipe_shift;
        issued_n = issued;
        num_n    = num;
        cnt_n    = cnt;
        sig_n    = sig;
`ifdef AES_SIG_GOLDEN_EN
        pass_n   = pass;
`endif
        // Start wins over a simultaneous capture: the in-flight sample is discarded.
        if (i_start) begin
            state_n  = ST_RUN;
            pipe_n   = '0;
            issued_n = '0;
            num_n    = i_num_tests;
            cnt_n    = '0;
            sig_n    = '0;
`ifdef AES_SIG_GOLDEN_EN
            pass_n   = 1'b0;
`endif
        end else if (state == ST_RUN) begin
            if (push) begin
                issued_n = issued + 1'b1;
            end
            if (tail) begin
                sig_n = misr_next;
                cnt_n = cnt + 1'b1;
            end
            if (cnt_n == num) begin
                state_n = ST_DONE;
`ifdef AES_SIG_GOLDEN_EN
                pass_n  = (sig_n == i_golden_sig);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pipe   <= '0;
            issued <= '0;
            num    <= '0;
            cnt    <= '0;
            sig    <= '0;
        end else begin
            state  <= state_n;
            pipe   <= pipe_n;
            issued <= issued_n;
            num    <= num_n;
            cnt    <= cnt_n;
            sig    <= sig_n;
        end
    end

`ifdef AES_SIG_GOLDEN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else begin
            pass <= pass_n;
        end
    end

    assign o_pass = pass;
`endif

    assign o_sig   = sig;
    assign o_count = cnt;
    assign o_busy  = (state == ST_RUN);
    assign o_done  = (state == ST_DONE);

endmodule

// File: tb/tb_aes_out_sig.sv
// tb/tb_aes_out_sig.sv - directed self-checking bench for aes_out_sig
module tb_aes_out_sig;

    localparam int DATA_W = 128;
    localparam int CNT_W  = 32;
    localparam logic [DATA_W-1:0] GARB = 128'hdeadbeef_cafef00d_12345678_9abcdef0;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic [CNT_W-1:0]  i_num_tests;
    logic              i_in_valid;
    logic [DATA_W-1:0] i_data;
    logic [DATA_W-1:0] o_sig;
    logic [CNT_W-1:0]  o_count;
    logic              o_busy;
    logic              o_done;
`ifdef AES_SIG_GOLDEN_EN
    logic [DATA_W-1:0] i_golden_sig;
    logic              o_pass;
`endif

    int errors = 0;
    int checks = 0;

    aes_out_sig #(.DATA_W(DATA_W), .LATENCY(21), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_num_tests (i_num_tests),
        .i_in_valid  (i_in_valid),
        .i_data      (i_data),
`ifdef AES_SIG_GOLDEN_EN
        .i_golden_sig(i_golden_sig),
        .o_pass      (o_pass),
`endif
        .o_sig       (o_sig),
        .o_count     (o_count),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [DATA_W-1:0] d);
        i_in_valid = v;
        i_data     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [CNT_W-1:0] n);
        i_start     = 1'b1;
        i_num_tests = n;
        i_in_valid  = 1'b0;
        i_data      = GARB;
        @(posedge clk);
        #1;
        i_start     = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_num_tests = '0;
        i_in_valid  = 1'b0;
        i_data      = GARB;
`ifdef AES_SIG_GOLDEN_EN
        i_golden_sig = 128'h2;
`endif
        #2;
        check("rst_sig", o_sig, 0);
        check("rst_count", o_count, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", o_busy, 0);

        // N=1, one issue at edge 0, sampled at edge 21
        start(1);
        check("n1_busy_after_start", o_busy, 1);
        check("n1_done_after_start", o_done, 0);
        for (int e = 0; e <= 25; e++) begin
            tick(e == 0, (e == 21) ? 128'h1 : GARB);
            if (e == 20) check("n1_count_e20", o_count, 0);
        end
        check("n1_sig", o_sig, 128'h1);
        check("n1_count", o_count, 1);
        check("n1_done", o_done, 1);
        check("n1_busy", o_busy, 0);

        // N=2 shift check
        start(2);
`ifdef AES_SIG_GOLDEN_EN
        check("pass_cleared_on_start", o_pass, 0);
`endif
        for (int e = 0; e <= 24; e++) begin
            tick(e < 2, (e == 21) ? 128'h1 : (e == 22) ? 128'h0 : GARB);
            if (e == 21) begin
                check("n2_count_e21", o_count, 1);
                check("n2_done_e21", o_done, 0);
            end
        end
        check("n2_sig", o_sig, 128'h2);
        check("n2_count", o_count, 2);
        check("n2_done", o_done, 1);
`ifdef AES_SIG_GOLDEN_EN
        check("golden2_pass", o_pass, 1);
        i_golden_sig = 128'h3;
        start(2);
        for (int e = 0; e <= 24; e++) begin
            tick(e < 2, (e == 21) ? 128'h1 : (e == 22) ? 128'h0 : GARB);
        end
        check("golden3_done", o_done, 1);
        check("golden3_pass", o_pass, 0);
`endif

        // Feedback from bit 127
        start(2);
        for (int e = 0; e <= 24; e++) begin
            tick(e < 2, (e == 21) ? {1'b1, 127'b0} : (e == 22) ? 128'h0 : GARB);
        end
        check("fb_sig", o_sig, 128'h1);
        check("fb_count", o_count, 2);

        // N=3 with five issue pulses
        start(3);
        for (int e = 0; e <= 27; e++) begin
            tick(e < 5, (e == 21) ? 128'h1 : (e == 22 || e == 23) ? 128'h0 : GARB);
        end
        check("n3_sig", o_sig, 128'h4);
        check("n3_count", o_count, 3);
        check("n3_done", o_done, 1);

        // N=0 finishes one edge after start
        start(0);
        check("n0_busy", o_busy, 1);
        tick(1'b0, GARB);
        check("n0_done", o_done, 1);
        check("n0_sig", o_sig, 0);
        check("n0_count", o_count, 0);

        // Restart at edge 10 flushes the pending issue from edge 0
        start(1);
        for (int e = 0; e <= 9; e++) tick(e == 0, GARB);
        start(1);
        for (int e = 11; e <= 33; e++) begin
            tick(e == 11, (e == 32) ? 128'h5 : (e == 21) ? 128'h1 : GARB);
            if (e == 21) check("restart_e21_count", o_count, 0);
        end
        check("restart_sig", o_sig, 128'h5);
        check("restart_count", o_count, 1);
        check("restart_done", o_done, 1);

        // Start coinciding with a tail bit drops that sample
        start(1);
        for (int e = 0; e <= 20; e++) tick(e == 0, GARB);
        i_data = 128'h1;
        start(1);
        check("simul_count", o_count, 0);
        check("simul_sig", o_sig, 0);
        check("simul_busy", o_busy, 1);
        for (int e = 0; e <= 3; e++) tick(1'b0, 128'h1);
        check("simul_count_later", o_count, 0);

        // Asynchronous reset mid-run
        start(2);
        for (int e = 0; e <= 21; e++) tick(e < 2, (e == 21) ? 128'h7 : GARB);
        check("prerst_sig", o_sig, 128'h7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sig", o_sig, 0);
        check("arst_count", o_count, 0);
        check("arst_busy", o_busy, 0);
        check("arst_done", o_done, 0);
`ifdef AES_SIG_GOLDEN_EN
        check("arst_pass", o_pass, 0);
`endif
        tick(1'b0, 128'hff);
        check("rst_low_count", o_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 128'hff);
        check("postrst_busy", o_busy, 0);
        check("postrst_sig", o_sig, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
